wb_select_stage: RTL and testbench

- Parametrised successor to the register-file write-back source selector.
- Selects one of N_SRC data sources, or a built-in constant, and registers the result with its destination register address.
- Delivers the result to the register-file write port through a valid/ready handshake, with a 2-entry skid buffer for full throughput.
- Adds invalid-select detection, write-to-$zero suppression and a write-back transfer counter; sits between the datapath source buses and the register file.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_skid_buffer.sv | 52 +++++
 rtl/wb_select_stage.sv | 81 ++++++++
 tb/tb_wb_select_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared write-back select definitions: source codes,
// built-in constant and default stage geometry.
package wb_pkg;

  localparam int WB_N_SRC = 11;
  localparam int WB_SEL_W = 4;
  localparam int WB_CONST = 227;

  typedef enum logic [3:0] {
    SEL_ALU   = 4'd0,
    SEL_MDR   = 4'd1,
    SEL_LO    = 4'd2,
    SEL_HI    = 4'd3,
    SEL_SHIFT = 4'd4,
    SEL_SX16  = 4'd5,
    SEL_LUI   = 4'd6,
    SEL_SX1   = 4'd7,
    SEL_CONST = 4'd8,
    SEL_A     = 4'd9,
    SEL_B     = 4'd10
  } wb_sel_e;

endpackage

// File: rtl/wb_skid_buffer.sv
// 2-entry valid/ready skid buffer (output reg + skid reg).
// Ports: in_valid/in_ready/in_data -> out_valid/out_ready/out_data.
module wb_skid_buffer #(
  parameter int DW = 37
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          push;
  logic          pop;

  // Ready comes straight from a flop: no path from out_ready.
  assign in_ready = !s_valid;
  assign push     = in_valid && !s_valid;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      s_valid   <= 1'b0;
      s_data    <= '0;
    end else if (pop) begin
      if (s_valid) begin
        out_data <= s_data;
        s_valid  <= 1'b0;
      end else if (push) begin
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        s_valid <= 1'b1;
        s_data  <= in_data;
      end
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// Write-back source select, $zero filter, error flag, beat counter.
// Ports: in_valid/in_ready/sel/src_flat/dst_addr in; out_* to regfile.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_SRC     = WB_N_SRC,
  parameter int SEL_W     = WB_SEL_W,
  parameter int CONST_IDX = int'(SEL_CONST),
  parameter int CONST_VAL = WB_CONST,
  parameter int ADDR_W    = 5,
  parameter int DROP_ZERO = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] src_flat,
  input  logic [ADDR_W-1:0]      dst_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   sel_err,
  input  logic                   err_clr,
  output logic [CNT_W-1:0]       wb_count
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             accept;
  logic             keep;

  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_bad  = 1'b0;
        sel_data = (i == CONST_IDX) ? WIDTH'(CONST_VAL)
                                    : src_flat[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = in_valid && in_ready;
  // $zero beats are consumed here and never reach the buffer.
  assign keep   = !((DROP_ZERO != 0) && (dst_addr == '0));

  wb_skid_buffer #(
    .DW(ADDR_W + WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (in_valid && keep),
    .in_ready (in_ready),
    .in_data  ({dst_addr, sel_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_addr, out_data})
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err  <= 1'b0;
      wb_count <= '0;
    end else begin
      if (accept && sel_bad) begin
        sel_err <= 1'b1;
      end else if (err_clr) begin
        sel_err <= 1'b0;
      end
      if (out_valid && out_ready) begin
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: vector table, hand sequences,
// randomized traffic against a queue-based reference model.
module tb_wb_select_stage;

  localparam int W  = 32;
  localparam int N  = 11;
  localparam int SW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          err_clr = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [N*W-1:0] src_flat = '0;
  logic [AW-1:0] dst_addr = '0;

  logic          in_ready, out_valid, sel_err;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic [15:0]   wb_count;

  logic          in_ready4, out_valid4, sel_err4;
  logic [W-1:0]  out_data4;
  logic [AW-1:0] out_addr4;
  logic [3:0]    wb_count4;

  always #5 clk = ~clk;

  wb_select_stage u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .src_flat(src_flat), .dst_addr(dst_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .sel_err(sel_err), .err_clr(err_clr), .wb_count(wb_count)
  );

  wb_select_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready4),
    .sel(sel), .src_flat(src_flat), .dst_addr(dst_addr),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_addr(out_addr4),
    .sel_err(sel_err4), .err_clr(err_clr), .wb_count(wb_count4)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } beat_t;

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  src;
    logic [AW-1:0] dst;
    logic [W-1:0]  exp_d;
    logic          exp_err;
  } vec_t;

  beat_t mq[$];
  bit    m_err;
  int    m_cnt;
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_val(input logic [SW-1:0] s,
                                           input logic [N*W-1:0] f);
    if (int'(s) >= N) return '0;
    if (int'(s) == 8) return 32'd227;
    return f[int'(s)*W +: W];
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0].d);
      chk("out_addr", out_addr, mq[0].a);
    end
    chk("sel_err", sel_err, m_err);
    chk("wb_count", wb_count, m_cnt % 65536);
    chk("wb_count4", wb_count4, m_cnt % 16);
  endtask

  // One clock: predict from inputs held across the edge, then compare.
  task automatic tick();
    bit    acc, drn, bad, clr;
    beat_t b;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    bad = int'(sel) >= N;
    clr = err_clr;
    b.a = dst_addr;
    b.d = ref_val(sel, src_flat);
    @(posedge clk);
    #1;
    if (drn) begin
      void'(mq.pop_front());
      m_cnt++;
    end
    if (acc && dst_addr != '0) mq.push_back(b);
    if (acc && bad) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_count", wb_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_sel_err", sel_err, 0);
    mq.delete();
    m_cnt = 0;
    m_err = 1'b0;
    in_valid = 1'b0;
    err_clr = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("rel_in_ready", in_ready, 1);
  endtask

  task automatic fill_bg();
    for (int i = 0; i < N; i++) src_flat[i*W +: W] = 32'hBAD0_0000 + i;
  endtask

  task automatic rand_src();
    for (int i = 0; i < N; i++) src_flat[i*W +: W] = $urandom;
  endtask

  vec_t vt[8];
  int   base;

  initial begin
    vt[0] = '{4'd0,  32'h1234_5678, 5'd5,  32'h1234_5678, 1'b0};
    vt[1] = '{4'd8,  32'h5555_5555, 5'd31, 32'h0000_00E3, 1'b0};
    vt[2] = '{4'd12, 32'h7777_7777, 5'd3,  32'h0000_0000, 1'b1};
    vt[3] = '{4'd10, 32'hCAFE_F00D, 5'd17, 32'hCAFE_F00D, 1'b0};
    vt[4] = '{4'd15, 32'h1111_1111, 5'd9,  32'h0000_0000, 1'b1};
    vt[5] = '{4'd1,  32'h0000_FFFF, 5'd30, 32'h0000_FFFF, 1'b0};
    vt[6] = '{4'd11, 32'h2222_2222, 5'd1,  32'h0000_0000, 1'b1};
    vt[7] = '{4'd7,  32'h8000_0001, 5'd2,  32'h8000_0001, 1'b0};

    do_reset();

    // Vector table, one beat at a time.
    foreach (vt[k]) begin
      fill_bg();
      if (int'(vt[k].sel) < N) src_flat[int'(vt[k].sel)*W +: W] = vt[k].src;
      sel = vt[k].sel;
      dst_addr = vt[k].dst;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", k), out_valid, 1);
      chk($sformatf("vec%0d_data", k), out_data, vt[k].exp_d);
      chk($sformatf("vec%0d_addr", k), out_addr, vt[k].dst);
      chk($sformatf("vec%0d_err", k), sel_err, vt[k].exp_err);
      if (k == 0) chk("first_count", wb_count, 0);
      in_valid = 1'b0;
      src_flat = '0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
    end
    chk("vec_count", wb_count, 8);

    // Invalid select colliding with err_clr: set wins.
    sel = 4'd12; dst_addr = 5'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("err_sticky", sel_err, 1);
    err_clr = 1'b1;
    tick();
    chk("err_cleared", sel_err, 0);
    sel = 4'd13; in_valid = 1'b1;
    tick();
    tick();
    chk("err_set_wins", sel_err, 1);
    in_valid = 1'b0; err_clr = 1'b0;
    tick();

    // Backpressure: A, B held, C waits; then drain in order.
    base = m_cnt;
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd0;
    for (int j = 1; j <= 3; j++) begin
      src_flat[0 +: W] = 32'hA000_0000 + j;
      dst_addr = AW'(j);
      tick();
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_addr", out_addr, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_addr", out_addr, 2);
    tick();
    chk("bp_c_addr", out_addr, 3);
    chk("bp_c_data", out_data, 32'hA000_0003);
    in_valid = 1'b0;
    tick();
    chk("bp_count", wb_count, 16'(base + 3));

    // $zero destination is consumed silently.
    base = m_cnt;
    sel = 4'd1; dst_addr = 5'd0; in_valid = 1'b1;
    tick();
    chk("zero_no_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk("zero_count", wb_count, 16'(base));

    // Streaming: 100 beats in 101 cycles.
    base = m_cnt;
    out_ready = 1'b1;
    for (int j = 0; j < 100; j++) begin
      rand_src();
      sel = SW'($urandom_range(0, 10));
      dst_addr = AW'($urandom_range(1, 31));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("stream_count", wb_count, 16'(base + 100));

    // Reset with both entries occupied.
    out_ready = 1'b0; in_valid = 1'b1; dst_addr = 5'd4;
    tick();
    tick();
    chk("full_in_ready", in_ready, 0);
    do_reset();

    // 16 beats wrap the 4-bit counter.
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      rand_src();
      sel = SW'($urandom_range(0, 10));
      dst_addr = AW'($urandom_range(1, 31));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap4", wb_count4, 0);
    chk("wrap16", wb_count, 16);

    // Random traffic.
    for (int j = 0; j < 400; j++) begin
      rand_src();
      sel = SW'($urandom_range(0, 15));
      dst_addr = AW'($urandom_range(0, 31));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    err_clr = 1'b0;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
